// File: rtl/spi_adc_amp_responder.sv
// Responder model of the SPI gain amplifier and dual-channel ADC seen by the capture master.
// All pins are oversampled on CLK; the ADC serves 34-edge frames and the amplifier accepts 8-bit gain writes.
module spi_adc_amp_responder #(
    parameter int                 DATA_W    = 14,
    parameter int                 FRAME_LEN = 34,
    parameter int                 GAIN_W    = 8,
    parameter logic [GAIN_W-1:0]  GAIN_RST  = 8'h11
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SPI_SCK,
    input  logic              SPI_MOSI,
    input  logic              AMP_CS,
    input  logic              AD_CONV,
    input  logic [DATA_W-1:0] CH0_SAMPLE,
    input  logic [DATA_W-1:0] CH1_SAMPLE,
    output logic              AD_DOUT,
    output logic              AMP_DOUT,
    output logic [GAIN_W-1:0] GAIN,
    output logic              GAIN_VALID,
    output logic              FRAME_DONE,
    output logic              BUSY
);
    localparam int FW    = 2 * DATA_W + 6;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // [0],[1] synchroniser stages, [2] delay flop for edge detection
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] mosi_sync_q, mosi_sync_d;
    logic [2:0] cs_sync_q, cs_sync_d;
    logic [2:0] conv_sync_q, conv_sync_d;

    state_t            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ad_dout_q, ad_dout_d;
    logic              done_q, done_d;

    logic [GAIN_W-1:0] rx_q, rx_d;
    logic [GAIN_W-1:0] rdbk_q, rdbk_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic              amp_dout_q, amp_dout_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              gvalid_q, gvalid_d;

    logic sck_rise, sck_fall, cs_rise, cs_fall, conv_rise;

    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], SPI_SCK};
        mosi_sync_d = {mosi_sync_q[1:0], SPI_MOSI};
        cs_sync_d   = {cs_sync_q[1:0], AMP_CS};
        conv_sync_d = {conv_sync_q[1:0], AD_CONV};
        sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
        cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
        cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
        conv_rise   = conv_sync_q[1] & ~conv_sync_q[2];
    end

    // ADC frame FSM; a new conversion always wins over an in-flight shift
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        ad_dout_d = ad_dout_q;
        done_d    = 1'b0;
        if (conv_rise) begin
            frame_d   = {2'b00, CH0_SAMPLE, 2'b00, CH1_SAMPLE, 2'b00};
            cnt_d     = '0;
            state_d   = SHIFT;
            ad_dout_d = frame_d[FW-1];
        end else if (state_q == SHIFT && sck_fall) begin
            frame_d = {frame_q[FW-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                ad_dout_d = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end else begin
                ad_dout_d = frame_q[FW-2];
            end
        end
    end

    // Amplifier path: receive on SCK rise, readback on SCK fall, commit only on an exact-length write
    always_comb begin
        rx_d       = rx_q;
        rdbk_d     = rdbk_q;
        bitcnt_d   = bitcnt_q;
        amp_dout_d = amp_dout_q;
        gain_d     = gain_q;
        gvalid_d   = 1'b0;
        if (cs_fall) begin
            rdbk_d     = gain_q;
            amp_dout_d = gain_q[GAIN_W-1];
            bitcnt_d   = '0;
            rx_d       = '0;
        end else if (cs_rise) begin
            amp_dout_d = 1'b0;
            if (bitcnt_q == 4'(GAIN_W)) begin
                gain_d   = rx_q;
                gvalid_d = 1'b1;
            end
        end else if (!cs_sync_q[1]) begin
            if (sck_rise) begin
                rx_d = {rx_q[GAIN_W-2:0], mosi_sync_q[1]};
                if (bitcnt_q != 4'hF) bitcnt_d = bitcnt_q + 4'd1;
            end
            if (sck_fall) begin
                rdbk_d     = {rdbk_q[GAIN_W-2:0], 1'b0};
                amp_dout_d = rdbk_q[GAIN_W-2];
            end
        end else begin
            amp_dout_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            conv_sync_q <= '0;
            state_q     <= IDLE;
            frame_q     <= '0;
            cnt_q       <= '0;
            ad_dout_q   <= 1'b0;
            done_q      <= 1'b0;
            rx_q        <= '0;
            rdbk_q      <= '0;
            bitcnt_q    <= '0;
            amp_dout_q  <= 1'b0;
            gain_q      <= GAIN_RST;
            gvalid_q    <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            conv_sync_q <= conv_sync_d;
            state_q     <= state_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            ad_dout_q   <= ad_dout_d;
            done_q      <= done_d;
            rx_q        <= rx_d;
            rdbk_q      <= rdbk_d;
            bitcnt_q    <= bitcnt_d;
            amp_dout_q  <= amp_dout_d;
            gain_q      <= gain_d;
            gvalid_q    <= gvalid_d;
        end
    end

    assign AD_DOUT    = ad_dout_q;
    assign AMP_DOUT   = amp_dout_q;
    assign GAIN       = gain_q;
    assign GAIN_VALID = gvalid_q;
    assign FRAME_DONE = done_q;
    assign BUSY       = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_adc_amp_responder.sv
// Directed plus randomized bench for spi_adc_amp_responder acting as an SPI master
// against a word-level model of the gain register and the ADC frame layout.
module tb_spi_adc_amp_responder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SPI_SCK = 1'b0;
    logic        SPI_MOSI = 1'b0;
    logic        AMP_CS = 1'b1;
    logic        AD_CONV = 1'b0;
    logic [13:0] CH0_SAMPLE = '0;
    logic [13:0] CH1_SAMPLE = '0;
    logic        AD_DOUT, AMP_DOUT, GAIN_VALID, FRAME_DONE, BUSY;
    logic [7:0]  GAIN;

    spi_adc_amp_responder dut (
        .CLK(CLK), .RST(RST), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
        .AMP_CS(AMP_CS), .AD_CONV(AD_CONV), .CH0_SAMPLE(CH0_SAMPLE),
        .CH1_SAMPLE(CH1_SAMPLE), .AD_DOUT(AD_DOUT), .AMP_DOUT(AMP_DOUT),
        .GAIN(GAIN), .GAIN_VALID(GAIN_VALID), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    int gv_seen = 0;
    logic [7:0] m_gain = 8'h11;

    always @(posedge CLK) begin
        if (FRAME_DONE === 1'b1) done_seen++;
        if (GAIN_VALID === 1'b1) gv_seen++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCK period: low phase then high phase; the master samples just before raising SCK.
    task automatic sck_cycle(input logic mosi, output logic ad_b, output logic amp_b);
        SPI_MOSI = mosi;
        wait_clk(5);
        ad_b  = AD_DOUT;
        amp_b = AMP_DOUT;
        SPI_SCK = 1'b1;
        wait_clk(5);
        SPI_SCK = 1'b0;
    endtask

    task automatic pulse_conv();
        AD_CONV = 1'b1;
        wait_clk(5);
        AD_CONV = 1'b0;
        wait_clk(2);
    endtask

    function automatic logic [63:0] exp_frame(input logic [13:0] c0, input logic [13:0] c1);
        return (64'(c0) << 18) | (64'(c1) << 2);
    endfunction

    task automatic amp_write(input logic [7:0] val, input int n, input string tag);
        logic a, b;
        logic [15:0] rbq;
        int gv0;
        gv0 = gv_seen;
        rbq = '0;
        AMP_CS = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            sck_cycle((i < 8) ? val[7-i] : 1'b1, a, b);
            rbq = {rbq[14:0], b};
        end
        wait_clk(2);
        AMP_CS = 1'b1;
        wait_clk(6);
        chk({tag, "_rdbk"}, 64'(rbq), 64'(({m_gain, 8'h00}) >> (16 - n)));
        if (n == 8) m_gain = val;
        chk({tag, "_gain"}, 64'(GAIN), 64'(m_gain));
        chk({tag, "_gv_pulses"}, 64'(gv_seen - gv0), (n == 8) ? 64'd1 : 64'd0);
        chk({tag, "_amp_idle"}, 64'(AMP_DOUT), 64'd0);
    endtask

    task automatic run_frame(input logic [13:0] c0, input logic [13:0] c1, input string tag);
        logic a, b;
        logic [63:0] got;
        int d0;
        d0 = done_seen;
        CH0_SAMPLE = c0;
        CH1_SAMPLE = c1;
        pulse_conv();
        chk({tag, "_busy_on"}, 64'(BUSY), 64'd1);
        got = '0;
        for (int i = 0; i < 34; i++) begin
            sck_cycle(1'b0, a, b);
            got = {got[62:0], a};
        end
        wait_clk(6);
        chk({tag, "_data"}, got, exp_frame(c0, c1));
        chk({tag, "_busy_off"}, 64'(BUSY), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_seen - d0), 64'd1);
    endtask

    initial begin
        logic a, b;
        logic [63:0] got;
        logic [15:0] rbq;
        logic [7:0]  val;
        int d0, g0;

        // reset state
        wait_clk(3);
        chk("rst_ad_dout", 64'(AD_DOUT), 64'd0);
        chk("rst_amp_dout", 64'(AMP_DOUT), 64'd0);
        chk("rst_gain", 64'(GAIN), 64'h11);
        chk("rst_gv", 64'(GAIN_VALID), 64'd0);
        chk("rst_done", 64'(FRAME_DONE), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        RST = 1'b0;
        wait_clk(10);

        amp_write(8'hA5, 8, "wr_a5");
        run_frame(14'h1ABC, 14'h2001, "frame_1abc");
        amp_write(8'h3C, 5, "wr_short");

        // abort after 10 falling edges, then restart with fresh channel data
        d0 = done_seen;
        CH0_SAMPLE = 14'h0123;
        CH1_SAMPLE = 14'h0456;
        pulse_conv();
        for (int i = 0; i < 10; i++) sck_cycle(1'b0, a, b);
        CH0_SAMPLE = 14'h3FFF;
        pulse_conv();
        got = '0;
        for (int i = 0; i < 34; i++) begin
            sck_cycle(1'b0, a, b);
            got = {got[62:0], a};
        end
        wait_clk(6);
        chk("abort_data", got, exp_frame(14'h3FFF, 14'h0456));
        chk("abort_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("abort_busy_off", 64'(BUSY), 64'd0);

        // asynchronous reset in the middle of a frame
        d0 = done_seen;
        CH0_SAMPLE = 14'h2AAA;
        CH1_SAMPLE = 14'h1555;
        pulse_conv();
        for (int i = 0; i < 20; i++) sck_cycle(1'b0, a, b);
        wait_clk(4);
        chk("midrst_busy_before", 64'(BUSY), 64'd1);
        RST = 1'b1;
        #1;
        chk("midrst_ad_dout", 64'(AD_DOUT), 64'd0);
        chk("midrst_busy", 64'(BUSY), 64'd0);
        wait_clk(3);
        RST = 1'b0;
        m_gain = 8'h11;
        wait_clk(8);
        chk("midrst_gain", 64'(GAIN), 64'h11);
        chk("midrst_no_done", 64'(done_seen - d0), 64'd0);
        run_frame(14'h2AAA, 14'h1555, "post_rst");

        // gain write overlapping a conversion frame
        val = 8'h5E;
        d0 = done_seen;
        g0 = gv_seen;
        CH0_SAMPLE = 14'h0F0F;
        CH1_SAMPLE = 14'h3001;
        AMP_CS = 1'b0;
        wait_clk(4);
        pulse_conv();
        got = '0;
        rbq = '0;
        for (int i = 0; i < 34; i++) begin
            sck_cycle((i < 8) ? val[7-i] : 1'b0, a, b);
            got = {got[62:0], a};
            if (i < 8) rbq = {rbq[14:0], b};
            if (i == 7) AMP_CS = 1'b1;
        end
        wait_clk(6);
        chk("ovl_rdbk", 64'(rbq), 64'(m_gain));
        m_gain = val;
        chk("ovl_gain", 64'(GAIN), 64'(m_gain));
        chk("ovl_gv_pulses", 64'(gv_seen - g0), 64'd1);
        chk("ovl_data", got, exp_frame(14'h0F0F, 14'h3001));
        chk("ovl_done_pulses", 64'(done_seen - d0), 64'd1);

        // randomized writes of varying length and random frames
        for (int k = 0; k < 4; k++) begin
            amp_write(8'($urandom), (k % 2 == 0) ? 8 : int'($urandom_range(3, 12)), "rnd_wr");
            run_frame(14'($urandom), 14'($urandom), "rnd_frame");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
